// File: rtl/osc_wave_gen_if.sv
// Control and sample bus of one tone-generator voice.
// The master side owns tick/en/step/wave_sel/gate; the slave side returns the sample.
interface osc_wave_gen_if #(
  parameter int BITLEN = 8,
  parameter int ACCW   = 16
);
  logic              tick;
  logic              en;
  logic [ACCW-1:0]   step;
  logic [1:0]        wave_sel;
  logic              gate;
  logic [BITLEN-1:0] sample_out;
  logic              sample_valid;
  logic              busy;

  modport master (
    output tick, en, step, wave_sel, gate,
    input  sample_out, sample_valid, busy
  );

  modport slave (
    input  tick, en, step, wave_sel, gate,
    output sample_out, sample_valid, busy
  );
endinterface

// File: rtl/osc_wave_gen.sv
// Tone generator voice: phase accumulator, waveform shaper and
// attack/sustain/release envelope, advanced once per sample tick.
//
// state     | meaning
// ----------+---------------------------------------------
// S_IDLE    | env held at 0, waiting for gate
// S_ATTACK  | env rising by ATK_STEP per tick toward MAX
// S_SUSTAIN | env held at MAX while gate stays high
// S_RELEASE | env falling by REL_STEP per tick toward 0
module osc_wave_gen #(
  parameter int BITLEN   = 8,
  parameter int ACCW     = 16,
  parameter int ATK_STEP = 1,
  parameter int REL_STEP = 1
) (
  input logic           clk,
  input logic           n_rst,
  osc_wave_gen_if.slave bus
);

  localparam logic [BITLEN-1:0] MAX = '1;
  // Compare limits are one bit wider so the subtraction cannot underflow.
  localparam logic [BITLEN:0] ATK_LIM = {1'b0, MAX} - (BITLEN+1)'(ATK_STEP);
  localparam logic [BITLEN:0] REL_LIM = (BITLEN+1)'(REL_STEP);

  typedef enum logic [1:0] {S_IDLE, S_ATTACK, S_SUSTAIN, S_RELEASE} env_state_t;

  env_state_t        state, state_nxt;
  logic [ACCW-1:0]   phase;
  logic [BITLEN-1:0] env, env_nxt;
  logic [BITLEN-1:0] p, t, wave;
  logic [BITLEN-1:0] sample_nxt;

  assign p = phase[ACCW-1 -: BITLEN];
  assign t = {p[BITLEN-2:0], 1'b0};

  // Shape the current phase into the selected waveform (wave_sel is live, not latched).
  always_comb begin
    wave = '0;
    case (bus.wave_sel)
      2'b00:   wave = p[BITLEN-1] ? '0 : MAX;
      2'b01:   wave = p;
      2'b10:   wave = p[BITLEN-1] ? ~t : t;
      default: wave = '0;
    endcase
  end

  // Upper half of the full-width product is the scaled sample.
  assign sample_nxt = BITLEN'(({{BITLEN{1'b0}}, wave} * {{BITLEN{1'b0}}, env}) >> BITLEN);

  // Envelope next-state and level; saturates at both ends instead of wrapping.
  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    case (state)
      S_IDLE: begin
        env_nxt = '0;
        if (bus.gate) state_nxt = S_ATTACK;
      end
      S_ATTACK: begin
        if (!bus.gate) begin
          state_nxt = S_RELEASE;
        end else if ({1'b0, env} >= ATK_LIM) begin
          env_nxt   = MAX;
          state_nxt = S_SUSTAIN;
        end else begin
          env_nxt = env + BITLEN'(ATK_STEP);
        end
      end
      S_SUSTAIN: begin
        env_nxt = MAX;
        if (!bus.gate) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (bus.gate) begin
          state_nxt = S_ATTACK;
        end else if ({1'b0, env} <= REL_LIM) begin
          env_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          env_nxt = env - BITLEN'(REL_STEP);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        env_nxt   = '0;
      end
    endcase
  end

  // State register: en=0 clears everything; otherwise only a tick moves anything.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= S_IDLE;
      env              <= '0;
      phase            <= '0;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
    end else if (!bus.en) begin
      state            <= S_IDLE;
      env              <= '0;
      phase            <= '0;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
    end else if (bus.tick) begin
      state            <= state_nxt;
      env              <= env_nxt;
      phase            <= phase + bus.step;
      bus.sample_out   <= sample_nxt;
      bus.sample_valid <= 1'b1;
    end else begin
      bus.sample_valid <= 1'b0;
    end
  end

  // Busy whenever a note is sounding or decaying.
  always_comb bus.busy = (state != S_IDLE);

endmodule

// File: tb/tb_osc_wave_gen.sv
// Randomized bench for osc_wave_gen with an arithmetic reference model and
// a scoreboard queue checked by an independent negedge monitor.
module tb_osc_wave_gen;
  localparam int BITLEN = 8;
  localparam int ACCW   = 16;
  localparam int ATK    = 64;
  localparam int REL    = 100;
  localparam int MAXV   = (1 << BITLEN) - 1;
  localparam int HALF   = 1 << (BITLEN - 1);
  localparam int PMOD   = 1 << ACCW;

  localparam int ST_IDLE = 0, ST_ATK = 1, ST_SUS = 2, ST_REL = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  osc_wave_gen_if #(.BITLEN(BITLEN), .ACCW(ACCW)) bus ();

  osc_wave_gen #(
    .BITLEN(BITLEN), .ACCW(ACCW), .ATK_STEP(ATK), .REL_STEP(REL)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int m_phase = 0;
  int m_env   = 0;
  int m_stage = ST_IDLE;
  int exp_out = 0;
  bit exp_valid = 1'b0;

  function automatic int wave_of(int ph, int sel);
    int p;
    p = ph / (1 << (ACCW - BITLEN));
    case (sel)
      0:       return (p < HALF) ? MAXV : 0;
      1:       return p;
      2:       return (p < HALF) ? 2 * p : (2 * MAXV + 1) - 2 * p;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on the same edges as the DUT, pushes expected samples.
  initial forever begin
    @(posedge clk or negedge n_rst);
    if (!n_rst) begin
      m_phase = 0; m_env = 0; m_stage = ST_IDLE;
      exp_out = 0; exp_valid = 1'b0;
      exp_q.delete();
    end else if (!bus.en) begin
      m_phase = 0; m_env = 0; m_stage = ST_IDLE;
      exp_out = 0; exp_valid = 1'b0;
    end else if (bus.tick) begin
      exp_out = (wave_of(m_phase, int'(bus.wave_sel)) * m_env) / (1 << BITLEN);
      exp_q.push_back(exp_out);
      exp_valid = 1'b1;
      m_phase = (m_phase + int'(bus.step)) % PMOD;
      case (m_stage)
        ST_IDLE: if (bus.gate) m_stage = ST_ATK;
        ST_ATK: begin
          if (!bus.gate) m_stage = ST_REL;
          else if (m_env + ATK >= MAXV) begin m_env = MAXV; m_stage = ST_SUS; end
          else m_env = m_env + ATK;
        end
        ST_SUS: if (!bus.gate) m_stage = ST_REL;
        default: begin
          if (bus.gate) m_stage = ST_ATK;
          else if (m_env <= REL) begin m_env = 0; m_stage = ST_IDLE; end
          else m_env = m_env - REL;
        end
      endcase
    end else begin
      exp_valid = 1'b0;
    end
  end

  // Monitor: compares DUT outputs mid-cycle, popping the scoreboard on each expected sample.
  initial forever begin
    @(negedge clk);
    chk("sample_valid", int'(bus.sample_valid), int'(exp_valid));
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: got sample %0d with no expected entry at %0t",
                 bus.sample_out, $time);
      end else begin
        chk("sample_out", int'(bus.sample_out), exp_q.pop_front());
      end
    end else begin
      chk("sample_hold", int'(bus.sample_out), exp_out);
    end
    chk("busy", int'(bus.busy), int'(m_stage != ST_IDLE));
  end

  task automatic drive(bit t, bit e, bit g, logic [1:0] ws, logic [ACCW-1:0] st);
    @(posedge clk);
    #2;
    bus.tick = t; bus.en = e; bus.gate = g; bus.wave_sel = ws; bus.step = st;
  endtask

  task automatic ticks(int n, bit g, logic [1:0] ws, logic [ACCW-1:0] st);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, g, ws, st);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 n_rst = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b1;
  endtask

  initial begin
    bit g;
    bus.tick = 1'b0; bus.en = 1'b0; bus.gate = 1'b0; bus.wave_sel = 2'b00; bus.step = '0;
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;

    // Reset mid-attack, then idle ticks with gate low.
    ticks(3, 1'b1, 2'b01, 16'h1000);
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'b00, 16'h1000);
      drive(1'b0, 1'b1, 1'b0, 2'b00, 16'h1000);
    end

    // Attack on a saw, through a phase wrap, release two ticks, retrigger.
    drive(1'b0, 1'b0, 1'b0, 2'b01, 16'h1000);
    ticks(20, 1'b1, 2'b01, 16'h1000);
    ticks(2, 1'b0, 2'b01, 16'h1000);
    ticks(3, 1'b1, 2'b01, 16'h1000);

    // Reach sustain at phase 0, then square and triangle at quarter-cycle steps.
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    ticks(5, 1'b1, 2'b00, 16'h0000);
    ticks(8, 1'b1, 2'b00, 16'h4000);
    ticks(8, 1'b1, 2'b10, 16'h4000);

    // Release to idle.
    ticks(4, 1'b0, 2'b01, 16'h0100);

    // en dropped mid-note with tick stuck high, then back-to-back ticks.
    ticks(4, 1'b1, 2'b00, 16'h2000);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 2'b00, 16'h2000);
    @(negedge clk);
    chk("en_clear_out", int'(bus.sample_out), 0);
    chk("en_clear_valid", int'(bus.sample_valid), 0);
    ticks(8, 1'b1, 2'b00, 16'h2000);

    // Randomized traffic.
    g = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      if ($urandom_range(0, 7) == 0) g = ~g;
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 24) != 0, g,
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 4095)));
    end

    drive(1'b0, 1'b1, 1'b0, 2'b00, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
